register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count including hardwired-zero x0; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, meaning number of write ports (1..2).
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  meaning reset, synchronous and active-low: asserted when 0, sampled only on the rising edge of clk.
REQ-007 SHALL have ports wr_en[NUM_WR]  in  1 each, wr_addr[NUM_WR]  in  AW each, and wr_data[NUM_WR]  in  WIDTH each, meaning the write ports.
REQ-008 SHALL have ports rd_addr[NUM_RD]  in  AW each, rd_data[NUM_RD]  out  WIDTH each, and rd_busy[NUM_RD]  out  1 each, meaning the read ports plus pending-write status.
REQ-009 SHALL have ports iss_en  in  1 and iss_addr  in  AW, meaning the issue port that marks a destination register pending.
REQ-010 SHALL have port wr_collide  out  1, meaning a sticky flag for a same-cycle multi-port write to one register.

Function
REQ-011 SHALL return 0 on rd_data and 0 on rd_busy for any read port whose rd_addr is 0.
REQ-012 SHALL ignore writes and issues to x0: no storage change, no busy change.
REQ-013 SHALL make rd_data combinational from stored contents: zero-cycle read latency; write visible the cycle after wr_en.
REQ-014 SHALL commit, on a clock edge with wr_en[i]=1 and wr_addr[i]!=0, wr_data[i] into the addressed register.
REQ-015 SHALL give the higher-index write port priority when two enabled ports target the same nonzero address.
REQ-016 SHALL set wr_collide to 1 on the clock edge after any REQ-015 conflict, and hold it at 1 until reset.
REQ-017 SHALL keep one busy bit per register: iss_en=1 with iss_addr!=0 sets the bit at the clock edge.
REQ-018 SHALL clear the busy bit of a register on the clock edge on which any write port commits to it.
REQ-019 SHALL leave the busy bit at 1 when issue and write target the same register in the same cycle, because issue wins.
REQ-020 SHALL set an already-busy register on re-issue with no error and no change.
REQ-021 SHALL drive rd_busy[k] from the busy bit of rd_addr[k], subject to REQ-011 and REQ-027.
REQ-022 SHALL treat a non-power-of-two DEPTH address at or above DEPTH as x0 for reads, writes and issues.

Reset
REQ-023 SHALL clear all registers to 0 on a clock edge with rst=0.
REQ-024 SHALL clear all busy bits to 0 on a clock edge with rst=0.
REQ-025 SHALL clear wr_collide to 0 on a clock edge with rst=0.
REQ-026 SHALL give reset priority over same-cycle writes and issues, which are discarded; rd_data reads 0 and rd_busy reads 0 from the first post-reset cycle.

Configuration
REQ-027 SHALL, when REGFILE_BYPASS_EN is defined, forward same-cycle writes combinationally: a read whose rd_addr matches an enabled nonzero wr_addr returns the winning wr_data (REQ-015) and rd_busy=0, unless iss_addr matches in the same cycle, in which case rd_busy=1.
REQ-028 SHALL, when REGFILE_BYPASS_EN is not defined, have no forwarding path: reads and rd_busy reflect registered state only, with no combinational path from wr_* or iss_* to rd_*.

Verification
REQ-029 SHALL cover reset then read: rst=0 for 2 cycles, then read x5 on both read ports -> rd_data=0 and rd_busy=0.
REQ-030 SHALL cover x0 protection: write 0xDEADBEEF to x0 via port 0 and issue x0 -> read x0 gives rd_data=0, rd_busy=0.
REQ-031 SHALL cover write conflict: port0 writes 0x11 to x3 and port1 writes 0x22 to x3 in one cycle -> next cycle x3=0x22 and wr_collide=1, still 1 ten cycles later.
REQ-032 SHALL cover scoreboard: issue x7, then write x7=0x5 two cycles later -> rd_busy=1 for 2 cycles, then 0 with rd_data=0x5; issue and write x7 together -> rd_busy stays 1.
REQ-033 SHALL cover bypass: write x9=0xA5A5A5A5 while reading x9 in the same cycle -> rd_data=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without it.
REQ-034 SHALL cover mid-operation reset: issue x4 and write x4=0x77 in the cycle rst=0 -> next cycle x4=0, rd_busy=0, wr_collide=0.

Source files
------------

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with hardwired x0, pending-write busy bits and sticky write-collision flag; optional same-cycle forwarding under REGFILE_BYPASS_EN
module register_file_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en   [NUM_WR],
    input  logic [AW-1:0]    wr_addr [NUM_WR],
    input  logic [WIDTH-1:0] wr_data [NUM_WR],
    input  logic [AW-1:0]    rd_addr [NUM_RD],
    output logic [WIDTH-1:0] rd_data [NUM_RD],
    output logic             rd_busy [NUM_RD],
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic             wr_collide
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             collide_q;
    logic             collide_d;
    logic             wr_ok [NUM_WR];
    logic             iss_ok;

    // x0 and any address beyond the last implemented register behave as x0
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < DEPTH);
    endfunction

    // qualify write and issue requests against x0 / out-of-range addresses
    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wr_ok[i] = wr_en[i] && addr_ok(wr_addr[i]);
        end
        iss_ok = iss_en && addr_ok(iss_addr);
    end

    // next storage: ascending port order so the higher-index port wins
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ok[i]) begin
                mem_d[wr_addr[i]] = wr_data[i];
            end
        end
    end

    // next busy bits: commits clear, then issue sets so issue wins a tie
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ok[i]) begin
                busy_d[wr_addr[i]] = 1'b0;
            end
        end
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    // sticky flag for two enabled ports hitting the same register
    always_comb begin
        collide_d = collide_q;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_ok[i] && wr_ok[j] && (wr_addr[i] == wr_addr[j])) begin
                    collide_d = 1'b1;
                end
            end
        end
    end

    // state registers with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q    <= '0;
            collide_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            busy_q    <= busy_d;
            collide_q <= collide_d;
        end
    end

    // read ports: combinational from stored state, optionally forwarding this cycle's writes
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k] = '0;
            rd_busy[k] = 1'b0;
            if (addr_ok(rd_addr[k])) begin
                rd_data[k] = mem_q[rd_addr[k]];
                rd_busy[k] = busy_q[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_ok[i] && (wr_addr[i] == rd_addr[k])) begin
                        rd_data[k] = wr_data[i];
                        rd_busy[k] = iss_ok && (iss_addr == rd_addr[k]);
                    end
                end
`endif
            end
        end
    end

    assign wr_collide = collide_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed self-checking bench for register_file_mp
module tb_register_file_mp;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en   [2];
    logic [AW-1:0]    wr_addr [2];
    logic [WIDTH-1:0] wr_data [2];
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];
    logic             rd_busy [2];
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             wr_collide;

    int checks   = 0;
    int failures = 0;

    register_file_mp dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .wr_collide (wr_collide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en[0] = 1'b0; wr_en[1] = 1'b0;
        wr_addr[0] = '0; wr_addr[1] = '0;
        wr_data[0] = '0; wr_data[1] = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;

        // reset held two cycles, then read x5 on both ports
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_rd0_data", rd_data[0], 32'h0);
        chk("rst_rd0_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("rst_rd1_data", rd_data[1], 32'h0);
        chk("rst_rd1_busy", {31'h0, rd_busy[1]}, 32'h0);
        chk("rst_collide", {31'h0, wr_collide}, 32'h0);

        // write and issue to x0 have no effect
        wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd0;
        tick(); idle();
        rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        #1;
        chk("x0_data", rd_data[0], 32'h0);
        chk("x0_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("x0_collide", {31'h0, wr_collide}, 32'h0);

        // same-cycle conflict on x3: port 1 wins, flag sticks
        wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h11;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd3; wr_data[1] = 32'h22;
        tick(); idle();
        rd_addr[1] = 5'd3;
        #1;
        chk("conf_data", rd_data[1], 32'h22);
        chk("conf_collide", {31'h0, wr_collide}, 32'h1);
        for (int n = 0; n < 10; n++) tick();
        chk("conf_collide_10", {31'h0, wr_collide}, 32'h1);

        // scoreboard: issue x7, busy two cycles, write clears it
        iss_en = 1'b1; iss_addr = 5'd7;
        tick(); idle();
        rd_addr[0] = 5'd7;
        #1;
        chk("sb_busy_c1", {31'h0, rd_busy[0]}, 32'h1);
        tick();
        chk("sb_busy_c2", {31'h0, rd_busy[0]}, 32'h1);
        wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h5;
        tick(); idle();
        #1;
        chk("sb_busy_clr", {31'h0, rd_busy[0]}, 32'h0);
        chk("sb_data", rd_data[0], 32'h5);
        // issue and write x7 together: issue wins
        iss_en = 1'b1; iss_addr = 5'd7;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'h9;
        tick(); idle();
        #1;
        chk("sb_iss_wins_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("sb_iss_wins_data", rd_data[0], 32'h9);
        // re-issue of an already-busy register
        iss_en = 1'b1; iss_addr = 5'd7;
        tick(); idle();
        #1;
        chk("sb_reissue_busy", {31'h0, rd_busy[0]}, 32'h1);

        // write on port 1 clears busy of x10
        iss_en = 1'b1; iss_addr = 5'd10;
        tick(); idle();
        rd_addr[1] = 5'd10;
        #1;
        chk("p1_busy_set", {31'h0, rd_busy[1]}, 32'h1);
        wr_en[1] = 1'b1; wr_addr[1] = 5'd10; wr_data[1] = 32'h123;
        tick(); idle();
        #1;
        chk("p1_busy_clr", {31'h0, rd_busy[1]}, 32'h0);
        chk("p1_data", rd_data[1], 32'h123);

        // same-cycle read of x9 while it is written
        rd_addr[0] = 5'd9;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rd_data[0], 32'hA5A5A5A5);
`else
        chk("byp_data", rd_data[0], 32'h0);
`endif
        chk("byp_busy", {31'h0, rd_busy[0]}, 32'h0);
        tick(); idle();
        #1;
        chk("byp_after", rd_data[0], 32'hA5A5A5A5);

        // two ports write x9 with a same-cycle issue
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h1111;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h2222;
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_prio_data", rd_data[0], 32'h2222);
        chk("byp_prio_busy", {31'h0, rd_busy[0]}, 32'h1);
`else
        chk("byp_prio_data", rd_data[0], 32'hA5A5A5A5);
        chk("byp_prio_busy", {31'h0, rd_busy[0]}, 32'h0);
`endif
        tick(); idle();
        #1;
        chk("prio_data", rd_data[0], 32'h2222);
        chk("prio_busy", {31'h0, rd_busy[0]}, 32'h1);

        // reset mid-operation discards same-cycle issue and write
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h77;
        rst = 1'b0;
        tick(); idle();
        rst = 1'b1;
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd3;
        #1;
        chk("mrst_data", rd_data[0], 32'h0);
        chk("mrst_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("mrst_collide", {31'h0, wr_collide}, 32'h0);
        chk("mrst_x3", rd_data[1], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
